// File: rtl/wb_uart_lite_if.sv
// Wishbone B4 classic bus bundle for wb_uart_lite.
//   wb_adr   word address (0=DATA 1=STATUS 2=DIV 3=reserved)
//   wb_wdat  write data          wb_sel  byte lanes (only lane 0 gates writes)
//   wb_we    write enable        wb_cyc / wb_stb  cycle and strobe
//   wb_rdat  read data, zero outside the ack cycle
//   wb_ack   one-cycle acknowledge
interface wb_uart_lite_if;
  logic [1:0]  wb_adr;
  logic [31:0] wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdat;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_wdat, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_rdat, wb_ack
  );

  modport slave (
    input  wb_adr, wb_wdat, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_rdat, wb_ack
  );
endinterface

// File: rtl/wb_uart_lite.sv
// Wishbone classic slave UART, 8N1, runtime clocks-per-bit divisor.
//   clock    bus clock, all logic on the rising edge
//   reset_n  synchronous active-low reset
//   bus      Wishbone slave port (wb_uart_lite_if.slave)
//   uart_rx  asynchronous serial input, idle high
//   uart_tx  serial output, idle high
// Registers: DATA (TX holding reg / RX FIFO head), STATUS, DIV, reserved.
// STATUS layout: bit4 overrun, bit3 frame_err, bit2 tx_busy, bit1 rx_full, bit0 rx_nonempty;
// writing 1 to bit3/bit4 clears the matching sticky flag.
module wb_uart_lite #(
  parameter int unsigned DEFAULT_DIV   = 208,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  wb_uart_lite_if.slave  bus,
  input  logic           uart_rx,
  output logic           uart_tx
);

  localparam int unsigned AW       = $clog2(RX_FIFO_DEPTH);
  localparam logic [15:0] DivReset = 16'(DEFAULT_DIV);
  localparam logic [15:0] DivMin   = 16'd16;
  localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  // Bus and register state
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_FIFO_DEPTH];

  // TX state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_load;

  // RX state
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_push, rx_ferr;

  logic req, stall, accept, wr_en, pop, push_ok, fifo_empty, fifo_full, tx_busy;
  logic unused_bits;

  assign unused_bits = ^{bus.wb_wdat[31:16], bus.wb_sel[3:1]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tx_busy    = hold_full_q | (tx_state_q != TxIdle);

  // Bus decode, register file and FIFO pointers
  always_comb begin
    req    = bus.wb_cyc & bus.wb_stb & ~ack_q;
    // A DATA write with a full holding reg is held off until the shifter takes the byte.
    stall  = req & bus.wb_we & (bus.wb_adr == 2'd0) & bus.wb_sel[0] & hold_full_q;
    accept = req & ~stall;
    wr_en  = accept & bus.wb_we & bus.wb_sel[0];
    ack_d  = accept;
    rdat_d = '0;
    pop    = 1'b0;

    if (accept && !bus.wb_we) begin
      case (bus.wb_adr)
        2'd0: begin
          if (!fifo_empty) begin
            rdat_d = {23'b0, 1'b1, mem_q[rd_ptr_q[AW-1:0]]};
            pop    = 1'b1;
          end
        end
        2'd1:    rdat_d = {27'b0, overrun_q, frame_err_q, tx_busy, fifo_full, ~fifo_empty};
        2'd2:    rdat_d = {16'b0, div_q};
        default: rdat_d = '0;
      endcase
    end

    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~tx_load;
    if (wr_en && bus.wb_adr == 2'd0) begin
      hold_d      = bus.wb_wdat[7:0];
      hold_full_d = 1'b1;
    end

    div_d = div_q;
    if (wr_en && bus.wb_adr == 2'd2) begin
      div_d = (bus.wb_wdat[15:0] < DivMin) ? DivMin : bus.wb_wdat[15:0];
    end

    // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
    push_ok   = rx_push & (~fifo_full | pop);
    wr_ptr_d  = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

    // Set beats a clearing write in the same cycle.
    frame_err_d = rx_ferr | (frame_err_q &
                  ~(wr_en && bus.wb_adr == 2'd1 && bus.wb_wdat[3]));
    overrun_d   = (rx_push & fifo_full & ~pop) | (overrun_q &
                  ~(wr_en && bus.wb_adr == 2'd1 && bus.wb_wdat[4]));
  end

  // TX FSM next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;

    unique case (tx_state_q)
      TxIdle: tx_load = hold_full_q;
      TxStart: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          // A byte already waiting starts straight away: no idle gap between frames.
          if (hold_full_q) tx_load = 1'b1;
          else             tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
    endcase

    if (tx_load) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_shift_d = hold_q;
      tx_div_d   = div_q;  // frame keeps this divisor even if DIV is rewritten
      tx_line_d  = 1'b0;
    end
  end

  // RX FSM next state; counters count down to the next sample point.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;

    case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_div_d   = div_q;
          rx_cnt_d   = (div_q >> 1) - 16'd1;
        end
      end
      RxStart: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RxIdle;  // glitch, not a start bit
          end else begin
            rx_state_d = RxData;
            rx_cnt_d   = rx_div_q - 16'd1;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = RxWait;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxWait: begin
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      div_q       <= DivReset;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_div_q    <= DivReset;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_line_q   <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_div_q    <= DivReset;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
    end else begin
      ack_q       <= ack_d;
      rdat_q      <= rdat_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
  end

  assign bus.wb_ack  = ack_q;
  assign bus.wb_rdat = rdat_q;
  assign uart_tx     = tx_line_q;

endmodule
